// File: rtl/pid_scheduler.sv
// Sequenced PID controller: one shared signed 9x13 multiplier accumulates the
// P, I and D terms over three states, then S_OUT shifts, saturates and publishes u.
//
// state | meaning
// IDLE  | waiting for a sample; i_clr honoured here
// S_P   | acc += K_p * e
// S_I   | acc += K_i * e_sum
// S_D   | acc += K_d * (e - e_prev), then e_prev <= e
// S_OUT | u <= clamp(acc >>> SHIFT), pulse u_valid
module pid_scheduler #(
    parameter int SHIFT = 4,
    parameter int ISAT  = 2047
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       sample_valid,
    input  logic [7:0] e,
    input  logic [7:0] K_p,
    input  logic [7:0] K_i,
    input  logic [7:0] K_d,
    input  logic       i_clr,
    output logic       busy,
    output logic [7:0] u,
    output logic       u_valid
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] S_P   = 3'd1;
    localparam logic [2:0] S_I   = 3'd2;
    localparam logic [2:0] S_D   = 3'd3;
    localparam logic [2:0] S_OUT = 3'd4;

    localparam logic signed [12:0] ISAT_HI = 13'(ISAT);
    localparam logic signed [12:0] ISAT_LO = -ISAT_HI;
    localparam logic signed [22:0] U_HI    = 23'sd127;
    localparam logic signed [22:0] U_LO    = -23'sd128;

    logic [2:0]         state_q, state_d;
    logic [7:0]         e_q, e_d;
    logic [7:0]         kp_q, kp_d;
    logic [7:0]         ki_q, ki_d;
    logic [7:0]         kd_q, kd_d;
    logic signed [11:0] e_sum_q, e_sum_d;
    logic [7:0]         e_prev_q, e_prev_d;
    logic signed [22:0] acc_q, acc_d;
    logic [7:0]         u_q, u_d;
    logic               u_valid_q, u_valid_d;

    logic signed [12:0] sum_base;
    logic signed [12:0] sum_raw;
    logic signed [8:0]  diff;
    logic signed [8:0]  mul_a;
    logic signed [12:0] mul_b;
    logic signed [21:0] prod;
    logic signed [22:0] acc_sh;

    // Shared datapath: gains enter as unsigned values with a zero sign bit.
    always_comb begin
        sum_base = i_clr ? 13'sd0 : {e_sum_q[11], e_sum_q};
        sum_raw  = sum_base + {{5{e[7]}}, e};
        diff     = {e_q[7], e_q} - {e_prev_q[7], e_prev_q};
        mul_a    = '0;
        mul_b    = '0;
        case (state_q)
            S_P: begin
                mul_a = {1'b0, kp_q};
                mul_b = {{5{e_q[7]}}, e_q};
            end
            S_I: begin
                mul_a = {1'b0, ki_q};
                mul_b = {e_sum_q[11], e_sum_q};
            end
            S_D: begin
                mul_a = {1'b0, kd_q};
                mul_b = {{4{diff[8]}}, diff};
            end
            default: ;
        endcase
        prod   = $signed({{13{mul_a[8]}}, mul_a}) * $signed({{9{mul_b[12]}}, mul_b});
        acc_sh = acc_q >>> SHIFT;
    end

    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        kp_d      = kp_q;
        ki_d      = ki_q;
        kd_d      = kd_q;
        e_sum_d   = e_sum_q;
        e_prev_d  = e_prev_q;
        acc_d     = acc_q;
        u_d       = u_q;
        u_valid_d = u_valid_q;
        if (ena) begin
            u_valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_clr) begin
                        e_sum_d  = '0;
                        e_prev_d = '0;
                    end
                    // sum_base already folds in a same-cycle clear
                    if (sample_valid) begin
                        e_d     = e;
                        kp_d    = K_p;
                        ki_d    = K_i;
                        kd_d    = K_d;
                        acc_d   = '0;
                        state_d = S_P;
                        if (sum_raw > ISAT_HI)
                            e_sum_d = ISAT_HI[11:0];
                        else if (sum_raw < ISAT_LO)
                            e_sum_d = ISAT_LO[11:0];
                        else
                            e_sum_d = sum_raw[11:0];
                    end
                end
                S_P: begin
                    acc_d   = acc_q + {prod[21], prod};
                    state_d = S_I;
                end
                S_I: begin
                    acc_d   = acc_q + {prod[21], prod};
                    state_d = S_D;
                end
                S_D: begin
                    acc_d    = acc_q + {prod[21], prod};
                    e_prev_d = e_q;
                    state_d  = S_OUT;
                end
                S_OUT: begin
                    if (acc_sh > U_HI)
                        u_d = 8'h7f;
                    else if (acc_sh < U_LO)
                        u_d = 8'h80;
                    else
                        u_d = acc_sh[7:0];
                    u_valid_d = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            e_q       <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            kd_q      <= '0;
            e_sum_q   <= '0;
            e_prev_q  <= '0;
            acc_q     <= '0;
            u_q       <= '0;
            u_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            e_q       <= e_d;
            kp_q      <= kp_d;
            ki_q      <= ki_d;
            kd_q      <= kd_d;
            e_sum_q   <= e_sum_d;
            e_prev_q  <= e_prev_d;
            acc_q     <= acc_d;
            u_q       <= u_d;
            u_valid_q <= u_valid_d;
        end
    end

    // The pulse flop is frozen while stalled, so the visible strobe is gated.
    assign busy    = (state_q != IDLE);
    assign u       = u_q;
    assign u_valid = u_valid_q & ena;

endmodule

// File: tb/tb_pid_scheduler.sv
// Scoreboard bench for pid_scheduler: a driver feeds directed and random samples
// to an arithmetic PID model, and a monitor checks every u_valid pulse against it.
module tb_pid_scheduler;

    localparam int SHIFT     = 4;
    localparam int ISAT      = 2047;
    localparam int USE_MODEL = 9999;

    logic       clk = 1'b0;
    logic       rst_n, ena, sample_valid, i_clr;
    logic [7:0] e, K_p, K_i, K_d;
    logic       busy, u_valid;
    logic [7:0] u;

    pid_scheduler #(.SHIFT(SHIFT), .ISAT(ISAT)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .sample_valid(sample_valid),
        .e(e), .K_p(K_p), .K_i(K_i), .K_d(K_d), .i_clr(i_clr),
        .busy(busy), .u(u), .u_valid(u_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     u;
        longint cyc;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;
    int     last_u = 0;
    int     m_esum = 0;
    int     m_eprev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_accept(input int ev, input int kp, input int ki, input int kd,
                                input bit clr, output int uexp);
        int acc;
        if (clr) begin
            m_esum  = 0;
            m_eprev = 0;
        end
        m_esum  = clampi(m_esum + ev, -ISAT, ISAT);
        acc     = kp * ev + ki * m_esum + kd * (ev - m_eprev);
        m_eprev = ev;
        uexp    = clampi(acc >>> SHIFT, -128, 127);
    endtask

    // Monitor: pops one expectation per pulse, otherwise u must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                chk("u_valid_late", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (u_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_u_valid", 1, 0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("u_value", $signed(u), x.u);
                    chk("u_latency", cyc, x.cyc);
                    last_u = x.u;
                end
            end else begin
                chk("u_hold", $signed(u), last_u);
            end
        end
    end

    // mode 0: quiet while busy; 1: random junk; 2: sample_valid and i_clr forced high
    task automatic drive_busy(input int mode);
        if (mode == 0) begin
            sample_valid = 1'b0;
            i_clr        = 1'b0;
        end else begin
            sample_valid = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            i_clr        = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) == 0);
            e            = 8'($urandom);
            K_p          = 8'($urandom);
            K_i          = 8'($urandom);
            K_d          = 8'($urandom);
        end
    endtask

    task automatic run_sample(input int ev, input int kp, input int ki, input int kd,
                              input bit clr, input int exp_u, input int mode,
                              input int stall_at, input int stall_len);
        int   um;
        exp_t x;
        @(negedge clk);
        chk("busy_idle", busy, 0);
        ena          = 1'b1;
        sample_valid = 1'b1;
        i_clr        = clr;
        e            = 8'(ev);
        K_p          = 8'(kp);
        K_i          = 8'(ki);
        K_d          = 8'(kd);
        model_accept(ev, kp, ki, kd, clr, um);
        if (exp_u != USE_MODEL) um = exp_u;
        x.u   = um;
        x.cyc = cyc + 5 + stall_len;
        sb.push_back(x);
        for (int k = 0; k < 4; k++) begin
            if (k == stall_at) begin
                repeat (stall_len) begin
                    @(negedge clk);
                    ena = 1'b0;
                    drive_busy(mode);
                    chk("busy_stall", busy, 1);
                end
            end
            @(negedge clk);
            ena = 1'b1;
            drive_busy(mode);
            chk("busy_run", busy, 1);
        end
    endtask

    task automatic reset_in_s_d();
        @(negedge clk);
        chk("busy_idle", busy, 0);
        ena          = 1'b1;
        sample_valid = 1'b1;
        i_clr        = 1'b0;
        e            = 8'd20;
        K_p          = 8'd16;
        K_i          = 8'd16;
        K_d          = 8'd16;
        repeat (3) begin
            @(negedge clk);
            drive_busy(0);
        end
        chk("busy_before_rst", busy, 1);
        #2;
        rst_n   = 1'b0;
        last_u  = 0;
        m_esum  = 0;
        m_eprev = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_u", u, 0);
        chk("rst_u_valid", u_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // e_sum=3, diff=3: 16*(3+3+3)>>>4 = 9
        run_sample(3, 16, 16, 16, 0, 9, 0, -1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        ena          = 1'b0;
        sample_valid = 1'b0;
        i_clr        = 1'b0;
        e            = '0;
        K_p          = '0;
        K_i          = '0;
        K_d          = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_u", u, 0);
        chk("reset_u_valid", u_valid, 0);
        rst_n = 1'b1;
        ena   = 1'b1;

        // proportional
        run_sample(5, 16, 0, 0, 1, 5, 0, -1, 0);
        run_sample(-5, 16, 0, 0, 0, -5, 0, -1, 0);
        // integral, including a same-cycle clear
        run_sample(1, 0, 16, 0, 1, 1, 0, -1, 0);
        run_sample(1, 0, 16, 0, 0, 2, 0, -1, 0);
        run_sample(1, 0, 16, 0, 0, 3, 0, -1, 0);
        run_sample(2, 0, 16, 0, 1, 2, 0, -1, 0);
        // output saturation
        run_sample(127, 255, 0, 0, 1, 127, 0, -1, 0);
        run_sample(-128, 255, 0, 0, 0, -128, 0, -1, 0);
        // integral windup: 17 x 127 clamps at 2047, then -128 leaves 1919
        run_sample(127, 0, 1, 0, 1, USE_MODEL, 0, -1, 0);
        for (int n = 0; n < 16; n++) run_sample(127, 0, 1, 0, 0, USE_MODEL, 0, -1, 0);
        run_sample(-128, 0, 1, 0, 0, 119, 0, -1, 0);
        // derivative
        run_sample(10, 0, 0, 16, 1, 10, 0, -1, 0);
        run_sample(10, 0, 0, 16, 0, 0, 0, -1, 0);
        run_sample(4, 0, 0, 16, 0, -6, 0, -1, 0);
        // three-cycle stall in S_I
        run_sample(5, 16, 0, 0, 1, 5, 0, 1, 3);
        // sample_valid and i_clr held high while busy must be ignored
        run_sample(1, 0, 16, 0, 1, 1, 2, -1, 0);
        run_sample(1, 0, 16, 0, 0, 2, 2, -1, 0);
        // abort in S_D
        reset_in_s_d();

        for (int n = 0; n < 150; n++) begin
            int sa, sl, ev, gmax;
            sa   = -1;
            sl   = 0;
            if ($urandom_range(0, 4) == 0) begin
                sa = int'($urandom_range(0, 3));
                sl = int'($urandom_range(1, 3));
            end
            ev   = int'($urandom_range(0, 255)) - 128;
            gmax = ($urandom_range(0, 1) == 0) ? 31 : 255;
            run_sample(ev, int'($urandom_range(0, gmax)), int'($urandom_range(0, gmax)),
                       int'($urandom_range(0, gmax)), ($urandom_range(0, 7) == 0),
                       USE_MODEL, 1, sa, sl);
        end

        @(negedge clk);
        ena          = 1'b1;
        sample_valid = 1'b0;
        i_clr        = 1'b0;
        repeat (8) @(negedge clk);
        if (sb.size() != 0) chk("pending_results", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
